// File: rtl/word_fifo_if.sv
// Handshake bundle for word_fifo: write side (in_*) and read side (out_*).
// The master modport is the environment around the FIFO (producer and consumer).
// The slave modport is the FIFO itself.
interface word_fifo_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/word_fifo.sv
// word_fifo: first-word-fall-through FIFO with an occupancy count and an optional
// high-water mark. Define WORD_FIFO_HWM_EN to build the high-water-mark register;
// without it hwm reads 0 and hwm_clr is ignored.
// DEPTH must be a power of two and at least 2 so the pointers wrap by overflow.
// The interface instance must be built with the same WIDTH as this module.
module word_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    word_fifo_if.slave    bus,
    output logic [CW-1:0] count,
    output logic [CW-1:0] hwm,
    input  logic          hwm_clr
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             push;
    logic             pop;

    // Handshake flags decode straight from the registered count; no in-to-out bypass.
    always_comb begin
        bus.in_ready  = (count_q != CW'(DEPTH));
        bus.out_valid = (count_q != '0);
        bus.out_data  = mem_q[rd_ptr_q];
        push          = bus.in_valid && bus.in_ready;
        pop           = bus.out_valid && bus.out_ready;
    end

    // Occupancy next state: simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage, pointers and count; reset clears every entry so out_data reads 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= bus.in_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
        end
    end

    assign count = count_q;

`ifdef WORD_FIFO_HWM_EN
    logic [CW-1:0] hwm_q;
    logic [CW-1:0] hwm_d;

    // Track the peak post-update count; a clear restarts from the current count.
    always_comb begin
        hwm_d = hwm_q;
        if (hwm_clr) begin
            hwm_d = count_d;
        end else if (count_d > hwm_q) begin
            hwm_d = count_d;
        end
    end

    // High-water-mark register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm = hwm_q;
`else
    // Port kept so both builds share one port list.
    logic unused_hwm_clr;
    assign unused_hwm_clr = hwm_clr;
    assign hwm            = '0;
`endif

endmodule

// File: doc/word_fifo.md
WORD_FIFO -- requirements
Module: word_fifo

Interface
REQ-001 Parameter WIDTH, default 8, sets the data word width in bits.
REQ-002 Parameter DEPTH, default 4, sets the number of storage entries; it SHALL be a power of two and at least 2.
REQ-003 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 in_valid  input  1  the upstream producer has a word on in_data.
REQ-006 in_ready  output  1  the block can accept a word this cycle.
REQ-007 in_data  input  WIDTH  the write word.
REQ-008 out_valid  output  1  out_data holds the oldest stored word.
REQ-009 out_ready  input  1  the downstream consumer takes out_data this cycle.
REQ-010 out_data  output  WIDTH  the read word.
REQ-011 count  output  $clog2(DEPTH)+1  the number of words currently stored.
REQ-012 hwm  output  $clog2(DEPTH)+1  the high-water mark of count.
REQ-013 hwm_clr  input  1  a synchronous clear of hwm.

Function
REQ-014 Push SHALL occur when in_valid && in_ready; pop SHALL occur when out_valid && out_ready.
REQ-015 in_ready SHALL equal (count != DEPTH), decoded combinationally from registered count.
REQ-016 out_valid SHALL equal (count != 0), decoded combinationally from registered count.
REQ-017 out_data SHALL equal mem[rd_ptr] (first-word-fall-through); it SHALL stay stable while out_valid && !out_ready.
REQ-018 Latency: a word pushed in cycle N SHALL be visible on out_data with out_valid=1 in cycle N+1 at the earliest; there is no combinational in-to-out bypass.
REQ-019 Push: mem[wr_ptr] <= in_data and wr_ptr increments; pop: rd_ptr increments.
REQ-020 wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and SHALL wrap from DEPTH-1 to 0 by natural overflow.
REQ-021 count update: push only +1; pop only -1; both or neither, unchanged.
REQ-022 Full (count==DEPTH): in_ready=0, so no push occurs; a pop in the same cycle SHALL reach count DEPTH-1, and in_ready SHALL be 1 the next cycle.
REQ-023 Empty (count==0): out_valid=0, so no pop occurs, whatever the value of out_ready.
REQ-024 Simultaneous push and pop at 0<count<DEPTH SHALL keep count and preserve FIFO order.
REQ-025 in_data SHALL be ignored when no push occurs; count SHALL never leave the range 0..DEPTH.

Reset
REQ-026 While rst_n==0 at a rising clk edge: wr_ptr=0, rd_ptr=0, count=0, hwm=0, and every mem entry=0.
REQ-027 Reset values of the outputs: in_ready=1, out_valid=0, out_data=0, count=0, hwm=0.
REQ-028 Reset mid-operation SHALL discard all stored words, and no push or pop SHALL occur in that cycle.
REQ-029 Reset SHALL take priority over push, pop and hwm_clr.

Configuration
REQ-030 Macro WORD_FIFO_HWM_EN SHALL compile the high-water-mark tracking in or out.
REQ-031 With the macro defined, each cycle hwm <= hwm_clr ? count_next : max(hwm, count_next), where count_next is the post-update count.
REQ-032 Without the macro, hwm SHALL be tied to 0, hwm_clr SHALL be ignored, and no hwm register SHALL exist; the port list SHALL be identical in both builds.

Verification
REQ-033 Reset, then push 0x11,0x22,0x33 with out_ready=0 -> count=3, out_data=0x11, out_valid=1, in_ready=1.
REQ-034 Push 0xA0..0xA3 (DEPTH=4) with out_ready=0 -> count=4 and in_ready=0; offered word 0xA4 is not stored; then pop 4 -> outputs 0xA0,0xA1,0xA2,0xA3 in order.
REQ-035 Full, then in_valid=1 and out_ready=1 in the same cycle -> pop only, count=3; the next cycle's push is accepted, count=4.
REQ-036 Continuous push and pop for 10 words 0x00..0x09 after one pre-fill -> count holds 1, order is preserved, and both pointers wrap at least twice.
REQ-037 Count=3, then rst_n=0 for one cycle with in_valid=1 -> count=0, out_valid=0, out_data=0, and the in_data of that cycle is not stored.
REQ-038 With WORD_FIFO_HWM_EN: fill to 3 then drain to 0 -> hwm=3; pulse hwm_clr at count=1 -> hwm=1. Without the macro -> hwm=0 throughout.
